// File: rtl/matrix_issue_scoreboard_if.sv
// Issue-side bundle of matrix_issue_scoreboard: program control, IMEM read port
// and the per-FU issue channels. The slave modport is the scoreboard's view.
interface matrix_issue_scoreboard_if #(
  parameter int unsigned NumFu     = 4,
  parameter int unsigned NumRegs   = 8,
  parameter int unsigned ImemDepth = 256,
  parameter int unsigned PayloadW  = 64
);
  localparam int unsigned LenW  = $clog2(ImemDepth) + 1;
  localparam int unsigned AddrW = $clog2(ImemDepth);
  localparam int unsigned FuW   = $clog2(NumFu) + 1;

  logic                start_i;
  logic [LenW-1:0]     prog_len_i;
  logic                ready_o;
  logic                done_o;
  logic                imem_en_o;
  logic [AddrW-1:0]    imem_addr_o;
  logic [FuW-1:0]      imem_fu_i;
  logic [NumRegs-1:0]  imem_regs_i;
  logic [PayloadW-1:0] imem_payload_i;
  logic [NumFu-1:0]    fu_valid_o;
  logic [PayloadW-1:0] fu_payload_o;
  logic [NumFu-1:0]    fu_ready_i;
  logic [NumFu-1:0]    fu_busy_i;

  modport slave (
    input  start_i, prog_len_i, imem_fu_i, imem_regs_i, imem_payload_i, fu_ready_i, fu_busy_i,
    output ready_o, done_o, imem_en_o, imem_addr_o, fu_valid_o, fu_payload_o
  );

  modport master (
    output start_i, prog_len_i, imem_fu_i, imem_regs_i, imem_payload_i, fu_ready_i, fu_busy_i,
    input  ready_o, done_o, imem_en_o, imem_addr_o, fu_valid_o, fu_payload_o
  );
endinterface

// File: rtl/matrix_issue_scoreboard.sv
// In-order issue scoreboard: fetches instructions from IMEM, issues each to
// one functional-unit channel, and tracks per-FU register claims to hold back
// instructions that touch registers still owned by an in-flight operation.
// Optional build macro: MATRIX_ISSUE_DDR_EXCLUSIVE_EN makes the DdrFuMask
// units mutually exclusive.
module matrix_issue_scoreboard #(
  parameter int unsigned      NumFu     = 4,
  parameter int unsigned      NumRegs   = 8,
  parameter int unsigned      ImemDepth = 256,
  parameter int unsigned      PayloadW  = 64,
  parameter logic [NumFu-1:0] DdrFuMask = NumFu'(4'b1100)
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  matrix_issue_scoreboard_if.slave bus
);
  localparam int unsigned LenW  = $clog2(ImemDepth) + 1;
  localparam int unsigned AddrW = $clog2(ImemDepth);
  localparam int unsigned FuW   = $clog2(NumFu) + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StDrain} state_e;

  state_e                          r_state, w_state_next;
  logic [LenW-1:0]                 r_pc, w_pc_next;
  logic [LenW-1:0]                 r_len, w_len_next;
  logic                            r_first;
  logic [FuW-1:0]                  r_fu;
  logic [NumRegs-1:0]              r_regs;
  logic [PayloadW-1:0]             r_payload;
  logic [NumFu-1:0]                r_valid, w_valid_next;
  logic [PayloadW-1:0]             r_fu_payload, w_fu_payload_next;
  logic [NumFu-1:0][NumRegs-1:0]   r_claim, w_claim_next;
  logic                            r_done, w_done_next;

  logic [FuW-1:0]      w_fu;
  logic [NumRegs-1:0]  w_regs;
  logic [PayloadW-1:0] w_payload;
  logic [NumFu-1:0]    w_sel;
  logic [NumFu-1:0]    w_claim_nz;
  logic [NumRegs-1:0]  w_claim_any;
  logic                w_is_op;
  logic                w_ddr_stall;
  logic                w_stall;
  logic                w_all_idle;
  logic [LenW-1:0]     w_len_clamped;

  // Instruction fields: live IMEM data on the first ISSUE cycle, captured copy afterwards.
  assign w_fu      = r_first ? bus.imem_fu_i      : r_fu;
  assign w_regs    = r_first ? bus.imem_regs_i    : r_regs;
  assign w_payload = r_first ? bus.imem_payload_i : r_payload;
  assign w_is_op   = (w_fu < FuW'(NumFu));

  assign w_len_clamped = (bus.prog_len_i > LenW'(ImemDepth)) ? LenW'(ImemDepth) : bus.prog_len_i;

  // Target decode and claim summaries; only registered claims feed the hazard check.
  always_comb begin
    w_sel       = '0;
    w_claim_nz  = '0;
    w_claim_any = '0;
    for (int k = 0; k < NumFu; k++) begin
      w_sel[k]      = (w_fu == FuW'(k));
      w_claim_nz[k] = |r_claim[k];
      w_claim_any   = w_claim_any | r_claim[k];
    end
  end

`ifdef MATRIX_ISSUE_DDR_EXCLUSIVE_EN
  assign w_ddr_stall = |(w_sel & DdrFuMask) &&
                       |(DdrFuMask & ~w_sel & (r_valid | bus.fu_busy_i | w_claim_nz));
`else
  // DdrFuMask only matters when exclusivity is built in.
  logic w_unused_ddr_mask;
  assign w_unused_ddr_mask = ^DdrFuMask;
  assign w_ddr_stall       = 1'b0;
`endif

  // Any pending valid blocks issue so that at most one channel is offered at a time.
  assign w_stall = w_is_op && ((|r_valid) || (|(w_sel & (bus.fu_busy_i | w_claim_nz))) ||
                               (|(w_regs & w_claim_any)) || w_ddr_stall);

  assign w_all_idle = ~(|r_valid) && ~(|bus.fu_busy_i) && ~(|w_claim_nz);

  // Next-state, channel handshake and claim bookkeeping.
  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_len_next        = r_len;
    w_done_next       = 1'b0;
    w_valid_next      = r_valid & ~bus.fu_ready_i;
    w_fu_payload_next = r_fu_payload;
    for (int k = 0; k < NumFu; k++) begin
      w_claim_next[k] = (!r_valid[k] && !bus.fu_busy_i[k]) ? '0 : r_claim[k];
    end
    unique case (r_state)
      StIdle: begin
        if (bus.start_i) begin
          w_len_next   = w_len_clamped;
          w_pc_next    = '0;
          w_state_next = (w_len_clamped == '0) ? StDrain : StFetch;
        end
      end
      StFetch: w_state_next = StIssue;
      StIssue: begin
        if (!w_stall) begin
          if (w_is_op) begin
            w_valid_next      = w_valid_next | w_sel;
            w_fu_payload_next = w_payload;
            for (int k = 0; k < NumFu; k++) begin
              if (w_sel[k]) w_claim_next[k] = w_regs;
            end
          end
          w_pc_next    = r_pc + LenW'(1);
          w_state_next = (r_pc == r_len - LenW'(1)) ? StDrain : StFetch;
        end
      end
      StDrain: begin
        if (w_all_idle) begin
          w_done_next  = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Control and channel state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= StIdle;
      r_pc         <= '0;
      r_len        <= '0;
      r_done       <= 1'b0;
      r_valid      <= '0;
      r_fu_payload <= '0;
      r_claim      <= '0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_len        <= w_len_next;
      r_done       <= w_done_next;
      r_valid      <= w_valid_next;
      r_fu_payload <= w_fu_payload_next;
      r_claim      <= w_claim_next;
    end
  end

  // Instruction capture on the first ISSUE cycle, held while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_first   <= 1'b0;
      r_fu      <= '0;
      r_regs    <= '0;
      r_payload <= '0;
    end else begin
      r_first <= (r_state == StFetch);
      if (r_state == StIssue && r_first) begin
        r_fu      <= bus.imem_fu_i;
        r_regs    <= bus.imem_regs_i;
        r_payload <= bus.imem_payload_i;
      end
    end
  end

  assign bus.ready_o      = (r_state == StIdle);
  assign bus.done_o       = r_done;
  assign bus.imem_en_o    = (r_state == StFetch);
  assign bus.imem_addr_o  = r_pc[AddrW-1:0];
  assign bus.fu_valid_o   = r_valid;
  assign bus.fu_payload_o = r_fu_payload;
endmodule

// File: tb/tb_matrix_issue_scoreboard.sv
// Bench for matrix_issue_scoreboard: an IMEM model and FU responders drive the
// design, a cycle-level reference model predicts every output, and directed
// programs pin the model with hand-computed cycle numbers.
module tb_matrix_issue_scoreboard;
  localparam int NumFu     = 4;
  localparam int NumRegs   = 8;
  localparam int ImemDepth = 256;
  localparam int PayloadW  = 64;
  localparam int FuW       = 3;
`ifdef MATRIX_ISSUE_DDR_EXCLUSIVE_EN
  localparam bit DdrEn = 1'b1;
`else
  localparam bit DdrEn = 1'b0;
`endif
  localparam int PhIdle = 0, PhFetch = 1, PhIssue = 2, PhDrain = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] ddr_mask = 4'b1100;

  matrix_issue_scoreboard_if #(
    .NumFu(NumFu), .NumRegs(NumRegs), .ImemDepth(ImemDepth), .PayloadW(PayloadW)
  ) bus ();

  matrix_issue_scoreboard #(
    .NumFu(NumFu), .NumRegs(NumRegs), .ImemDepth(ImemDepth), .PayloadW(PayloadW),
    .DdrFuMask(4'b1100)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [FuW-1:0]      mem_fu   [ImemDepth];
  logic [NumRegs-1:0]  mem_regs [ImemDepth];
  logic [PayloadW-1:0] mem_pay  [ImemDepth];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  int                  m_ph, m_pc, m_len, m_fu;
  bit                  m_first, m_done;
  logic [7:0]          m_regs;
  logic [63:0]         m_pay, m_out_pay;
  bit   [3:0]          m_valid;
  logic [7:0]          m_claim [4];

  // FU responder / IMEM state
  int   bcnt [4];
  int   hold_left [4];
  bit   [3:0] hold_mask;
  int   busy_fixed;
  bit   rdy_all, stray_en, last_en;
  int   last_addr;

  // Per-program records, cycles relative to the start cycle
  int s_cyc, done_at, en_cnt, first_addr;
  int rise [4];
  int vcnt [4];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic m_reset();
    m_ph = PhIdle; m_pc = 0; m_len = 0; m_fu = 0; m_first = 0; m_done = 0;
    m_regs = '0; m_pay = '0; m_out_pay = '0; m_valid = '0;
    for (int k = 0; k < 4; k++) m_claim[k] = '0;
  endtask

  // One clock edge of the scoreboard as described by its rules.
  task automatic m_step(input bit st, input int len, input int ifu, input logic [7:0] iregs,
                        input logic [63:0] ipay, input bit [3:0] rdy, input bit [3:0] bsy);
    bit [3:0]   nvalid;
    logic [7:0] nclaim [4];
    logic [7:0] claim_or;
    bit         busy_any, hz;
    int         f;
    logic [7:0] r;
    logic [63:0] p;
    nvalid   = m_valid & ~rdy;
    claim_or = '0;
    busy_any = 0;
    for (int k = 0; k < 4; k++) begin
      claim_or  = claim_or | m_claim[k];
      nclaim[k] = (!m_valid[k] && !bsy[k]) ? 8'h00 : m_claim[k];
    end
    m_done = 0;
    case (m_ph)
      PhIdle: if (st) begin
        m_len = (len > ImemDepth) ? ImemDepth : len;
        m_pc  = 0;
        m_ph  = (m_len == 0) ? PhDrain : PhFetch;
      end
      PhFetch: begin m_ph = PhIssue; m_first = 1; end
      PhIssue: begin
        if (m_first) begin m_fu = ifu; m_regs = iregs; m_pay = ipay; end
        m_first = 0;
        f = m_fu; r = m_regs; p = m_pay;
        hz = 0;
        if (f < NumFu) begin
          hz = (m_valid != 0) || bsy[f] || (m_claim[f] != 0) || ((r & claim_or) != 0);
          if (DdrEn && ddr_mask[f])
            for (int j = 0; j < 4; j++)
              if (j != f && ddr_mask[j] && (m_valid[j] || bsy[j] || m_claim[j] != 0)) hz = 1;
        end
        if (!hz) begin
          if (f < NumFu) begin nvalid[f] = 1; m_out_pay = p; nclaim[f] = r; end
          m_ph = (m_pc == m_len - 1) ? PhDrain : PhFetch;
          m_pc++;
        end
      end
      default: begin
        for (int k = 0; k < 4; k++) if (m_claim[k] != 0 || bsy[k]) busy_any = 1;
        if (m_valid == 0 && !busy_any) begin m_done = 1; m_ph = PhIdle; end
      end
    endcase
    m_valid = nvalid;
    for (int k = 0; k < 4; k++) m_claim[k] = nclaim[k];
  endtask

  task automatic clear_rec();
    done_at = -1; en_cnt = 0; first_addr = -1;
    for (int k = 0; k < 4; k++) begin rise[k] = -1; vcnt[k] = 0; end
  endtask

  // One cycle: compare at the falling edge, then drive this cycle's inputs and advance the model.
  task automatic step(input bit st, input int len);
    bit [3:0]    rdy, bsy;
    int          ifu;
    logic [7:0]  iregs;
    logic [63:0] ipay;
    bit          sv;
    int          lv;
    @(negedge clk);
    chk("ready_o", bus.ready_o, m_ph == PhIdle);
    chk("done_o", bus.done_o, m_done);
    chk("imem_en_o", bus.imem_en_o, m_ph == PhFetch);
    chk("imem_addr_o", bus.imem_addr_o, m_pc % ImemDepth);
    chk("fu_valid_o", bus.fu_valid_o, m_valid);
    chk("fu_payload_o", bus.fu_payload_o, m_out_pay);
    for (int k = 0; k < 4; k++)
      if (bus.fu_valid_o[k]) begin
        vcnt[k]++;
        if (rise[k] < 0) rise[k] = cyc - s_cyc;
      end
    if (bus.done_o && done_at < 0) done_at = cyc - s_cyc;
    if (bus.imem_en_o) begin
      en_cnt++;
      if (first_addr < 0) first_addr = int'(bus.imem_addr_o);
    end
    for (int k = 0; k < 4; k++) begin
      bsy[k] = (bcnt[k] > 0);
      if (bcnt[k] > 0) bcnt[k]--;
      rdy[k] = rdy_all ? 1'b1 : ($urandom_range(3) != 0);
      if (hold_mask[k] && bus.fu_valid_o[k] && hold_left[k] > 0) begin
        rdy[k] = 1'b0;
        hold_left[k]--;
      end
      if (bus.fu_valid_o[k] && rdy[k])
        bcnt[k] = (busy_fixed >= 0) ? busy_fixed : int'($urandom_range(4));
    end
    if (last_en) begin
      ifu = int'(mem_fu[last_addr]); iregs = mem_regs[last_addr]; ipay = mem_pay[last_addr];
    end else begin
      ifu = int'($urandom_range(7)); iregs = 8'($urandom); ipay = {$urandom, $urandom};
    end
    last_en   = bus.imem_en_o;
    last_addr = int'(bus.imem_addr_o);
    sv = st || (stray_en && m_ph != PhIdle && $urandom_range(7) == 0);
    lv = st ? len : int'($urandom_range(20));
    if (st) s_cyc = cyc;
    bus.start_i        = sv;
    bus.prog_len_i     = 9'(lv);
    bus.imem_fu_i      = 3'(ifu);
    bus.imem_regs_i    = iregs;
    bus.imem_payload_i = ipay;
    bus.fu_ready_i     = rdy;
    bus.fu_busy_i      = bsy;
    if (rst_n) m_step(sv, lv, ifu, iregs, ipay, rdy, bsy);
    else m_reset();
    cyc++;
  endtask

  task automatic run_prog(input int len, input int budget);
    clear_rec();
    step(1'b1, len);
    for (int i = 0; i < budget && done_at < 0; i++) step(1'b0, 0);
    chk("program completes", done_at >= 0, 1);
    step(1'b0, 0);
  endtask

  task automatic env_reset();
    for (int k = 0; k < 4; k++) begin bcnt[k] = 0; hold_left[k] = 0; end
    hold_mask = '0; last_en = 0; last_addr = 0;
  endtask

  task automatic put(input int a, input int f, input logic [7:0] r);
    mem_fu[a] = 3'(f); mem_regs[a] = r; mem_pay[a] = {$urandom, $urandom};
  endtask

  initial begin
    bus.start_i = 0; bus.prog_len_i = '0; bus.imem_fu_i = '0; bus.imem_regs_i = '0;
    bus.imem_payload_i = '0; bus.fu_ready_i = '0; bus.fu_busy_i = '0;
    for (int a = 0; a < ImemDepth; a++) put(a, 4, 8'h00);
    env_reset();
    m_reset();
    clear_rec();
    busy_fixed = 2; rdy_all = 1; stray_en = 0; s_cyc = 0;
    step(1'b0, 0);
    chk("reset ready_o", bus.ready_o, 1);
    chk("reset fu_valid_o", bus.fu_valid_o, 0);
    chk("reset fu_payload_o", bus.fu_payload_o, 0);
    step(1'b0, 0);
    rst_n = 1'b1;
    step(1'b0, 0);

    // Three independent instructions
    put(0, 0, 8'h01); put(1, 1, 8'h02); put(2, 2, 8'h04);
    busy_fixed = 2;
    run_prog(3, 200);
    chk("indep FU0 valid cycle", rise[0], 3);
    chk("indep FU1 valid cycle", rise[1], 5);
    chk("indep FU2 valid cycle", rise[2], 7);
    chk("indep done cycle", done_at, 12);

    // Register hazard across FUs
    put(0, 0, 8'h01); put(1, 1, 8'h01);
    busy_fixed = 10;
    run_prog(2, 300);
    chk("hazard FU1 valid cycle", rise[1], 16);

    // Back-pressure on FU1
    put(0, 1, 8'h02); put(1, 0, 8'h01);
    busy_fixed = 1; hold_mask = 4'b0010; hold_left[1] = 5;
    run_prog(2, 300);
    chk("backpressure FU1 valid cycles", vcnt[1], 6);
    chk("backpressure FU0 valid cycle", rise[0], 10);
    env_reset();

    // DDR pair FU2 then FU3
    put(0, 2, 8'h01); put(1, 3, 8'h02);
    busy_fixed = 3;
    run_prog(2, 300);
    chk("ddr FU2 valid cycle", rise[2], 3);
    chk("ddr FU3 valid cycle", rise[3], DdrEn ? 9 : 5);

    // Empty program and NOP
    run_prog(0, 50);
    chk("empty done cycle", done_at, 2);
    chk("empty imem reads", en_cnt, 0);
    put(0, 4, 8'hff);
    run_prog(1, 50);
    chk("nop done cycle", done_at, 4);
    chk("nop valids", vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3], 0);

    // Length clamp
    for (int a = 0; a < ImemDepth; a++) put(a, 4 + (a % 4), 8'h00);
    run_prog(300, 2000);
    chk("clamp imem reads", en_cnt, ImemDepth);

    // Reset mid-program with FU1 waiting
    put(0, 1, 8'h02); put(1, 0, 8'h01);
    hold_mask = 4'b0010; hold_left[1] = 50;
    clear_rec();
    step(1'b1, 2);
    for (int i = 0; i < 4; i++) step(1'b0, 0);
    chk("pre-reset FU1 valid cycle", rise[1], 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset fu_valid_o", bus.fu_valid_o, 0);
    chk("async reset ready_o", bus.ready_o, 1);
    chk("async reset imem_en_o", bus.imem_en_o, 0);
    m_reset();
    env_reset();
    step(1'b0, 0);
    step(1'b0, 0);
    rst_n = 1'b1;
    step(1'b0, 0);
    run_prog(2, 300);
    chk("restart first imem addr", first_addr, 0);
    chk("restart FU1 valid cycle", rise[1], 3);

    // Randomized programs with stray starts, random ready and busy lengths
    rdy_all = 0; busy_fixed = -1; stray_en = 1;
    for (int t = 0; t < 40; t++) begin
      int len;
      len = int'($urandom_range(12));
      for (int a = 0; a < 12; a++)
        put(a, int'($urandom_range(5)), 8'($urandom & $urandom & $urandom));
      run_prog(len, 1500);
    end
    stray_en = 0;
    step(1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
